// File: rtl/prb_et_seq.sv
// Handshaked precision/rebalancing detector: captures operands, registers don't-care masks
// and k_init, then streams a masked index counter. Optional abort port: PRB_ET_ABORT_EN.
module prb_et_seq #(
  parameter int W        = 8,
  parameter int N        = 2,
  parameter int S_GROUPS = 2,
  parameter int CORR     = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         ready,
  input  logic [W-1:0] Bxs [N],
  output logic [W-1:0] S [S_GROUPS],
  output logic [W-1:0] k_init,
  output logic [W-1:0] cnt,
  output logic         cnt_valid,
  input  logic         cnt_ready,
  output logic         cnt_last,
  output logic         busy
`ifdef PRB_ET_ABORT_EN
  ,
  input  logic         abort
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, RUN} state_t;

  state_t       state;
  logic [W-1:0] bxs_q [N];
  logic [W-1:0] m_q;
  logic [W-1:0] bx_or;
  logic [W-1:0] ell;
  logic [W-1:0] k_calc;
  logic [W-1:0] s_calc [S_GROUPS];
  logic [W-1:0] m_calc;
  logic [W-1:0] cnt_next;
  logic         seen;
  logic         abort_req;

`ifdef PRB_ET_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Ones strictly below the lowest set bit; a zero operand yields all ones.
  function automatic logic [W-1:0] tz(input logic [W-1:0] x);
    return ~x & (x - W'(1));
  endfunction

  always_comb begin
    bx_or  = '0;
    ell    = '0;
    k_calc = '0;
    seen   = 1'b0;
    m_calc = '1;
    for (int n = 0; n < N; n++) bx_or = bx_or | bxs_q[n];
    for (int i = W - 1; i >= 0; i--) begin
      if (!seen && bx_or[i]) k_calc[i] = 1'b1;
      if (bx_or[i]) seen = 1'b1;
      ell[i] = !seen;
    end
    for (int g = 0; g < S_GROUPS; g++) begin
      if (CORR == 0) s_calc[g] = tz(bxs_q[g]) | ell;
      else           s_calc[g] = tz(bx_or) | ell;
      m_calc = m_calc & s_calc[g];
    end
  end

  // Carry ripples through masked positions because they are forced to one before the add.
  assign cnt_next = ((cnt | m_q) + W'(1)) & ~m_q;

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m_q       <= '0;
      k_init    <= '0;
      cnt       <= '0;
      cnt_valid <= 1'b0;
      cnt_last  <= 1'b0;
      for (int n = 0; n < N; n++) bxs_q[n] <= '0;
      for (int g = 0; g < S_GROUPS; g++) S[g] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int n = 0; n < N; n++) bxs_q[n] <= Bxs[n];
            state <= CALC;
          end
        end
        CALC: begin
          if (abort_req) begin
            state <= IDLE;
          end else begin
            for (int g = 0; g < S_GROUPS; g++) S[g] <= s_calc[g];
            k_init    <= k_calc;
            m_q       <= m_calc;
            cnt       <= '0;
            cnt_valid <= 1'b1;
            cnt_last  <= (m_calc == '1);
            state     <= RUN;
          end
        end
        RUN: begin
          if (abort_req || (cnt_ready && cnt_last)) begin
            state     <= IDLE;
            cnt       <= '0;
            cnt_valid <= 1'b0;
            cnt_last  <= 1'b0;
          end else if (cnt_ready) begin
            cnt      <= cnt_next;
            cnt_last <= ((cnt_next | m_q) == '1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/prb_et_seq.md
# prb_et_seq

Sequential, handshaked successor to the combinational precision/rebalancing detector for stochastic-computing early termination. It accepts N W-bit binary operands and registers the per-group don't-care masks S and the one-hot initial precision k_init. It then emits a masked stream-index counter that visits only the significant bit positions, so the downstream SNG stops after 2^(significant bits) cycles instead of 2^W.

## Interface
- W, 8: operand and counter width.
- N, 2: number of operands.
- S_GROUPS, 2: number of mask groups; must equal N when CORR=0, must be 1 when CORR=1.
- CORR, 0: 0 = trailing-zero detection per operand; 1 = single trailing-zero detection on the OR of all operands.
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to load a new operand set.
- ready  output  1  block idle, start accepted this cycle when start&&ready.
- Bxs  input  [W-1:0] x N  operands, sampled only on an accepted start.
- S  output  [W-1:0] x S_GROUPS  registered don't-care masks.
- k_init  output  W  registered one-hot leading-one position of the OR of operands.
- cnt  output  W  current stream index.
- cnt_valid  output  1  cnt is a valid beat.
- cnt_ready  input  1  downstream accepts beat.
- cnt_last  output  1  current beat is the final one of the run.
- busy  output  1  state is not IDLE.
- abort  input  1  present only with PRB_ET_ABORT_EN.

## Operation
- States: IDLE -> CALC -> RUN -> IDLE.
- IDLE: ready=1. On start, Bxs is captured into internal registers and the state moves to CALC.
- CALC (1 cycle): computes the masks and registers S, k_init, the run mask M, and cnt=0.
  - Bx_or = bitwise OR of all operands.
  - ell[i]=1 for every i above the MSB index of Bx_or.
  - tz(x)[i]=1 for every i below the LSB index of x.
  - If Bx_or==0, ell = all ones and k_init = 0.
  - If an operand x==0, tz(x) = all ones.
  - CORR=0: S[g] = tz(Bxs[g]) | ell. CORR=1: S[0] = tz(Bx_or) | ell.
  - M = bitwise AND of all S[g].
  - k_init[p]=1 only at p = MSB index of Bx_or.
- RUN: cnt_valid=1.
  - The beat transfers when cnt_valid && cnt_ready. Without cnt_ready, cnt and cnt_last hold.
  - cnt_last = ((cnt | M) == all ones).
  - On a non-last transfer: cnt <= ((cnt | M) + 1) & ~M. Masked bits stay 0; unmasked bits count with carry propagating through masked positions.
  - On the last transfer: the state moves to IDLE, cnt_valid=0, and cnt resets to 0.
- Run length = 2^(W - popcount(M)) beats. If M is all ones, the run is one beat with cnt=0 and cnt_last=1.
- S and k_init hold their values from CALC until the next CALC; they do not change in RUN or IDLE.
- start while not IDLE is ignored; ready=0 in this case.

## Timing
- Reset values:
  - state IDLE, ready=1, busy=0.
  - S all 0, k_init 0, cnt 0.
  - cnt_valid 0, cnt_last 0.
- start accepted at edge T: CALC is active during T..T+1. S and k_init are valid after edge T+1; the first beat (cnt=0, cnt_valid=1) is presented after edge T+1.
- With cnt_ready held high, one beat transfers per cycle.
- After the last transfer at edge E, ready=1 from E. The earliest next start is accepted at edge E+1.
- Reset asserted mid-CALC or mid-RUN returns all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- PRB_ET_ABORT_EN defined: the abort port exists. abort=1 in CALC or RUN forces IDLE on the next edge, with cnt_valid=0, cnt_last=0 and cnt=0. S and k_init keep their last values. abort has priority over a simultaneous last transfer. abort in IDLE has no effect.
- PRB_ET_ABORT_EN undefined: no abort port; a run always completes.

## Test plan
- W=4, N=2, CORR=0, Bxs={0100,0110} -> S={1011,1001}, k_init=0100, M=1001; beats cnt=0000,0010,0100,0110; cnt_last on 0110.
- Same operands, CORR=1, S_GROUPS=1 -> S[0]=1001, k_init=0100; same 4 beats.
- Bxs={0000,0000} -> S all 1111, k_init=0000; a single beat cnt=0000 with cnt_last=1; ready=1 the next cycle.
- Bxs={1000,0001}, CORR=0 -> S={0111,0000}, M=0000; 16 beats 0..15; cnt_last only on 1111.
- Backpressure: first test's operands with cnt_ready=0 for 3 cycles at beat cnt=0010 -> cnt holds 0010 and cnt_valid stays 1; the sequence then resumes at 0100. A start pulse during the run is ignored.
- Reset and abort:
  - rst_n low for 1 cycle at beat 2 of the 16-beat run -> all outputs at reset values; a new start then runs normally.
  - With PRB_ET_ABORT_EN, abort at beat 5 -> IDLE next edge and cnt_valid=0.
